// File: rtl/issue_pkg.sv
// Shared encodings for the issue stage: dispatch-unit codes, the
// always-true condition code and a one-hot register mask helper.
package issue_pkg;

  typedef enum logic [1:0] {
    UNIT_ALU = 2'b00,
    UNIT_MUL = 2'b01,
    UNIT_FP  = 2'b10
  } unit_e;

  localparam logic [3:0] COND_AL = 4'hE;

  localparam int unsigned NREGS = 16;

  function automatic logic [NREGS-1:0] reg_mask(input logic [3:0] r);
    return NREGS'(1) << r;
  endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Register/flag scoreboard: one pending bit per architectural register
// plus a single flag-pending bit. Sets win over same-cycle clears, and
// clears only become visible on the following cycle.
module issue_scoreboard
  import issue_pkg::*;
(
  input  logic             CLK,
  input  logic             Reset,
  input  logic             set_en_i,
  input  logic [3:0]       set_reg_i,
  input  logic             set_flag_i,
  input  logic             mul_clr_i,
  input  logic [3:0]       mul_clr_reg_i,
  input  logic             fp_clr_i,
  input  logic [3:0]       fp_clr_reg_i,
  output logic [NREGS-1:0] pending_o,
  output logic             flag_pend_o
);

  logic [NREGS-1:0] pend_q, pend_d;
  logic             flag_q, flag_d;
  logic [NREGS-1:0] clr_mask, set_mask;

  // Next scoreboard state: apply writeback clears, then dispatch sets on top.
  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (mul_clr_i) clr_mask = clr_mask | reg_mask(mul_clr_reg_i);
    if (fp_clr_i)  clr_mask = clr_mask | reg_mask(fp_clr_reg_i);
    if (set_en_i)  set_mask = reg_mask(set_reg_i);
    pend_d = (pend_q & ~clr_mask) | set_mask;
    flag_d = (flag_q & ~mul_clr_i) | set_flag_i;
  end

  // Scoreboard registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      pend_q <= '0;
      flag_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      flag_q <= flag_d;
    end
  end

  assign pending_o   = pend_q;
  assign flag_pend_o = flag_q;

endmodule

// File: rtl/issue_stage.sv
// Issue stage: hazard detection against the scoreboard, multiplier
// busy counter and registered dispatch outputs.
// Optional FP path enabled by defining ISSUE_FP_EN; without it FP
// instructions are dropped and reported on UndefE.
module issue_stage
  import issue_pkg::*;
#(
  parameter int unsigned MUL_LAT = 4
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       IssueI,
  input  logic [3:0] RA1I,
  input  logic [3:0] RA2I,
  input  logic [3:0] WA3I,
  input  logic       ALUSrcI,
  input  logic       RegWI,
  input  logic       NoWriteI,
  input  logic       MULSI,
  input  logic       FPSI,
  input  logic       PCSI,
  input  logic [3:0] CondI,
  input  logic [3:0] FlagWI,
  input  logic       FPReady,
  input  logic       MulDoneW,
  input  logic       FPDoneW,
  input  logic [3:0] MulWA3W,
  input  logic [3:0] FPWA3W,
  output logic       StallI,
  output logic       IssueE,
  output logic [1:0] UnitE,
  output logic       UndefE
);

  localparam logic [2:0] MUL_LOAD = 3'(MUL_LAT - 1);

  logic [NREGS-1:0] pending;
  logic             flag_pend;
  logic [2:0]       busy_q, busy_d;
  logic             issue_q, undef_q;
  unit_e            unit_q, unit_sel;

  logic writes, src_haz, waw_haz, flag_haz, pc_haz, struct_haz;
  logic fp_struct, fp_clr, fp_drop;
  logic dispatch, mul_disp, tracked;

`ifdef ISSUE_FP_EN
  assign fp_struct = FPSI & ~FPReady;
  assign fp_clr    = FPDoneW;
  assign fp_drop   = 1'b0;
`else
  logic unused_fp;
  assign unused_fp = ^{FPReady, FPDoneW, FPWA3W};
  assign fp_struct = 1'b0;
  assign fp_clr    = 1'b0;
  assign fp_drop   = FPSI & ~MULSI;
`endif

  assign writes     = RegWI & ~NoWriteI;
  assign src_haz    = pending[RA1I] | (~ALUSrcI & pending[RA2I]);
  assign waw_haz    = writes & pending[WA3I];
  assign flag_haz   = flag_pend & ((CondI != COND_AL) | (FlagWI != 4'h0));
  assign pc_haz     = PCSI & ((|pending) | flag_pend);
  assign struct_haz = (MULSI & (busy_q != '0)) | fp_struct;

  assign StallI   = IssueI & (src_haz | waw_haz | flag_haz | pc_haz | struct_haz);
  assign dispatch = IssueI & ~StallI;
  assign mul_disp = dispatch & MULSI;
  // Dropped FP ops are "dispatched" for flow purposes but never scoreboarded.
  assign tracked  = dispatch & ~fp_drop & (MULSI | FPSI);

  // Target unit selection; MUL wins when both unit selects are raised.
  always_comb begin
    unit_sel = UNIT_ALU;
    if (MULSI)     unit_sel = UNIT_MUL;
    else if (FPSI) unit_sel = UNIT_FP;
  end

  // Multiplier busy counter: reload on MUL dispatch, count down, hold at zero.
  always_comb begin
    busy_d = busy_q;
    if (mul_disp)            busy_d = MUL_LOAD;
    else if (busy_q != '0)   busy_d = busy_q - 3'd1;
  end

  issue_scoreboard u_sb (
    .CLK           (CLK),
    .Reset         (Reset),
    .set_en_i      (tracked & writes),
    .set_reg_i     (WA3I),
    .set_flag_i    (mul_disp & (FlagWI != 4'h0)),
    .mul_clr_i     (MulDoneW),
    .mul_clr_reg_i (MulWA3W),
    .fp_clr_i      (fp_clr),
    .fp_clr_reg_i  (FPWA3W),
    .pending_o     (pending),
    .flag_pend_o   (flag_pend)
  );

  // Registered dispatch outputs and busy counter.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      issue_q <= 1'b0;
      undef_q <= 1'b0;
      unit_q  <= UNIT_ALU;
      busy_q  <= '0;
    end else begin
      issue_q <= dispatch & ~fp_drop;
      undef_q <= dispatch & fp_drop;
      if (dispatch & ~fp_drop) unit_q <= unit_sel;
      busy_q  <= busy_d;
    end
  end

  assign IssueE = issue_q;
  assign UndefE = undef_q;
  assign UnitE  = unit_q;

endmodule
